memory_bus_interface: RTL and testbench

MEMORY_BUS_INTERFACE -- requirements
Module: memory_bus_interface

---
 rtl/memory_bus_interface_pkg.sv | 24 ++
 rtl/memory_bus_interface_if.sv | 42 ++++
 rtl/memory_bus_interface_bus_timeout_counter.sv | 37 +++
 rtl/memory_bus_interface.sv | 139 +++++++++++++
 tb/tb_memory_bus_interface.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bus_interface_pkg.sv
// Shared definitions for the CPU-to-memory bus bridge: access FSM states,
// default timeout/open-bus parameters and the timeout counter width helper.
package memory_bus_interface_pkg;

  // Access sequencer states: idle, waiting for memory, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  // WAIT cycles without mem_ack before the access is abandonned (0 = never).
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  // Value a read returns when nothing on the bus answered.
  localparam logic [7:0] DEFAULT_OPEN_BUS_VALUE = 8'hFF;

  // Bits needed to count from 0 up to and including the timeout value;
  // a zero timeout still gets a one-bit counter so the port is never empty.
  function automatic int unsigned timeout_count_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/memory_bus_interface_if.sv
// Signal bundle between the CPU control/datapath, the bus bridge and memory.
// The bridge uses the slave view (it serves CPU requests and drives the memory
// side); the environment (CPU plus memory) uses the master view.
interface memory_bus_interface_if;

  // CPU side
  logic [7:0]  cpu_addr_high;
  logic [7:0]  cpu_addr_low;
  logic [7:0]  cpu_write_data;
  logic        cpu_read_req;
  logic        cpu_write_req;
  logic [7:0]  cpu_read_data;
  logic        cpu_ready;

  // Memory side
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        bus_error;

  modport slave (
    input  cpu_addr_high, cpu_addr_low, cpu_write_data,
    input  cpu_read_req, cpu_write_req,
    output cpu_read_data, cpu_ready,
    output mem_addr, mem_wdata, mem_we, mem_req,
    input  mem_ack, mem_rdata,
    output bus_error
  );

  modport master (
    output cpu_addr_high, cpu_addr_low, cpu_write_data,
    output cpu_read_req, cpu_write_req,
    input  cpu_read_data, cpu_ready,
    input  mem_addr, mem_wdata, mem_we, mem_req,
    output mem_ack, mem_rdata,
    input  bus_error
  );

endinterface

// File: rtl/memory_bus_interface_bus_timeout_counter.sv
// Counts WAIT cycles that pass without an acknowledge and flags the cycle in
// which the timeout is reached. A zero TIMEOUT_CYCLES disables expiry.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned WIDTH          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,   // start of a new access
  input  logic i_enable,  // a WAIT cycle with no acknowledge
  output logic o_expire   // this un-acked cycle is the last one allowed
);

  localparam bit             NEVER_ABORT = (TIMEOUT_CYCLES == 0);
  localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] FULL_COUNT = WIDTH'(TIMEOUT_CYCLES);

  logic [WIDTH-1:0] r_count;

  // Expiry is seen during the un-acked cycle that brings the count to the limit,
  // so the bridge can leave WAIT on that same edge.
  assign o_expire = !NEVER_ABORT && i_enable && (r_count == LAST_COUNT);

  // Clear on access start, otherwise count un-acked WAIT cycles up to the limit.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !NEVER_ABORT && (r_count != FULL_COUNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/memory_bus_interface.sv
// Bridge between the CPU's address/data registers and a request/acknowledge
// memory bus. One access at a time: latch in IDLE, hold the bus in WAIT until
// acknowledge or timeout, report completion for exactly one DONE cycle.
module memory_bus_interface
  import memory_bus_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [7:0]  OPEN_BUS_VALUE = DEFAULT_OPEN_BUS_VALUE
) (
  input  logic                   clk,
  input  logic                   rst,
  memory_bus_interface_if.slave  bus
);

  localparam int unsigned COUNT_WIDTH = timeout_count_width(TIMEOUT_CYCLES);

  bus_state_t  r_state;
  bus_state_t  w_next_state;

  logic        w_req;          // any CPU request this cycle
  logic        w_start;        // accept a request and enter WAIT
  logic        w_ack_done;     // memory acknowledged in WAIT
  logic        w_abort;        // timeout reached in WAIT without acknowledge
  logic        w_expire;
  logic        w_count_enable;
  logic        w_cpu_ready;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic [7:0]  r_read_data;
  logic        r_bus_error;

  assign w_req          = bus.cpu_read_req | bus.cpu_write_req;
  assign w_count_enable = (r_state == WAIT) && !bus.mem_ack;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WIDTH          (COUNT_WIDTH)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start),
    .i_enable (w_count_enable),
    .o_expire (w_expire)
  );

  // State register; reset drops any access in flight without reporting it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, access events and the combinational ready flag.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_start      = 1'b0;
    w_ack_done   = 1'b0;
    w_abort      = 1'b0;
    w_cpu_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cpu_ready = !w_req;
        if (w_req) begin
          w_start      = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        // An acknowledge in the timeout cycle still counts as a completion.
        if (bus.mem_ack) begin
          w_ack_done   = 1'b1;
          w_next_state = DONE;
        end else if (w_expire) begin
          w_abort      = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        // Requests seen here are ignored; the CPU re-issues them in IDLE.
        w_cpu_ready  = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Memory-side request, address/data latch and the abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 8'h00;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= w_abort;
      if (w_start) begin
        // A simultaneous read and write is performed as the write.
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.cpu_write_req;
        r_mem_addr  <= {bus.cpu_addr_high, bus.cpu_addr_low};
        r_mem_wdata <= bus.cpu_write_data;
      end else if (w_ack_done || w_abort) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  // Read data holds until the next read finishes, by acknowledge or by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= 8'h00;
    end else if (!r_mem_we) begin
      if (w_ack_done) begin
        r_read_data <= bus.mem_rdata;
      end else if (w_abort) begin
        r_read_data <= OPEN_BUS_VALUE;
      end
    end
  end

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.bus_error     = r_bus_error;
  assign bus.cpu_read_data = r_read_data;
  assign bus.cpu_ready     = w_cpu_ready;

endmodule

// File: tb/tb_memory_bus_interface.sv
// Self-checking bench for memory_bus_interface. Each access is described as a
// transaction (kind, address, data, which WAIT cycle acknowledges, read data);
// the expected per-cycle bus picture is derived from that description and
// compared against the DUT on every falling edge.
module tb_memory_bus_interface;

  localparam int unsigned T        = 16;
  localparam logic [7:0]  OPEN_BUS = 8'hFF;

  logic clk;
  logic rst;

  memory_bus_interface_if bus ();

  memory_bus_interface #(
    .TIMEOUT_CYCLES (T),
    .OPEN_BUS_VALUE (OPEN_BUS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the current cycle
  logic        exp_valid;
  logic        exp_bus_chk;   // address/data/we are defined (WAIT or reset)
  logic        exp_req;
  logic        exp_we;
  logic        exp_err;
  logic        exp_ready;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata;
  logic [7:0]  exp_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int req_hi_cycles   = 0;
  int ready_lo_cycles = 0;
  int err_hi_cycles   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Per-cycle comparison against the transaction model
  always @(negedge clk) begin
    if (exp_valid) begin
      check("mem_req",       32'(bus.mem_req),       32'(exp_req));
      check("bus_error",     32'(bus.bus_error),     32'(exp_err));
      check("cpu_ready",     32'(bus.cpu_ready),     32'(exp_ready));
      check("cpu_read_data", 32'(bus.cpu_read_data), 32'(exp_rdata));
      if (exp_bus_chk) begin
        check("mem_addr",  32'(bus.mem_addr),  32'(exp_addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
        check("mem_we",    32'(bus.mem_we),    32'(exp_we));
      end
      if (bus.mem_req === 1'b1)   req_hi_cycles++;
      if (bus.cpu_ready === 1'b0) ready_lo_cycles++;
      if (bus.bus_error === 1'b1) err_hi_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random_cpu();
    bus.cpu_addr_high  = 8'($urandom);
    bus.cpu_addr_low   = 8'($urandom);
    bus.cpu_write_data = 8'($urandom);
  endtask

  task automatic set_reset_expect();
    exp_req     = 1'b0;
    exp_we      = 1'b0;
    exp_err     = 1'b0;
    exp_ready   = 1'b1;
    exp_addr    = 16'h0000;
    exp_wdata   = 8'h00;
    exp_rdata   = 8'h00;
    exp_bus_chk = 1'b1;
  endtask

  // n IDLE cycles with no request; stray acknowledges must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.cpu_read_req  = 1'b0;
      bus.cpu_write_req = 1'b0;
      drive_random_cpu();
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = 8'($urandom);
      exp_req     = 1'b0;
      exp_err     = 1'b0;
      exp_ready   = 1'b1;
      exp_bus_chk = 1'b0;
    end
    if (n > 0) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One access: request cycle, WAIT cycles, DONE cycle.
  // ack_at = WAIT cycle carrying mem_ack; 0 or > T means never acknowledged.
  task automatic do_access(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [7:0] wd, input int ack_at, input logic [7:0] rdv);
    bit acked;
    int n_wait;
    acked  = (ack_at >= 1) && (ack_at <= int'(T));
    n_wait = acked ? ack_at : int'(T);

    tick();
    bus.cpu_read_req   = rd;
    bus.cpu_write_req  = wr;
    bus.cpu_addr_high  = addr[15:8];
    bus.cpu_addr_low   = addr[7:0];
    bus.cpu_write_data = wd;
    bus.mem_ack        = 1'($urandom);
    bus.mem_rdata      = 8'($urandom);
    exp_req     = 1'b0;
    exp_err     = 1'b0;
    exp_ready   = 1'b0;
    exp_bus_chk = 1'b0;
    req_hi_cycles   = 0;
    ready_lo_cycles = 0;
    err_hi_cycles   = 0;

    for (int w = 1; w <= n_wait; w++) begin
      tick();
      bus.cpu_read_req  = 1'($urandom);
      bus.cpu_write_req = 1'($urandom);
      drive_random_cpu();
      bus.mem_ack   = acked && (w == ack_at);
      bus.mem_rdata = (acked && (w == ack_at)) ? rdv : 8'($urandom);
      exp_req     = 1'b1;
      exp_addr    = addr;
      exp_wdata   = wd;
      exp_we      = wr;
      exp_err     = 1'b0;
      exp_ready   = 1'b0;
      exp_bus_chk = 1'b1;
    end

    tick();
    bus.cpu_read_req  = 1'($urandom);
    bus.cpu_write_req = 1'($urandom);
    drive_random_cpu();
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = 8'($urandom);
    exp_req     = 1'b0;
    exp_err     = !acked;
    exp_ready   = 1'b1;
    exp_bus_chk = 1'b0;
    if (rd && !wr) exp_rdata = acked ? rdv : OPEN_BUS;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    exp_valid   = 1'b0;
    exp_bus_chk = 1'b0;
    bus.cpu_read_req  = 1'b0;
    bus.cpu_write_req = 1'b0;
    drive_random_cpu();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;

    // Reset values
    #2;
    check("rst_mem_req",   32'(bus.mem_req),       32'h0);
    check("rst_mem_we",    32'(bus.mem_we),        32'h0);
    check("rst_mem_addr",  32'(bus.mem_addr),      32'h0000);
    check("rst_mem_wdata", 32'(bus.mem_wdata),     32'h00);
    check("rst_rdata",     32'(bus.cpu_read_data), 32'h00);
    check("rst_bus_error", 32'(bus.bus_error),     32'h0);
    check("rst_ready",     32'(bus.cpu_ready),     32'h1);
    bus.cpu_write_req = 1'b1;
    #1;
    check("rst_ready_req", 32'(bus.cpu_ready), 32'h0);
    bus.cpu_write_req = 1'b0;
    #1;
    set_reset_expect();
    exp_valid = 1'b1;
    tick();
    tick();
    rst         = 1'b0;
    exp_bus_chk = 1'b0;
    idle(3);

    // Read 16'h1234, ack on first WAIT cycle
    do_access(1'b1, 1'b0, 16'h1234, 8'h00, 1, 8'hA5);
    check("r1234_ready_lo", 32'(ready_lo_cycles), 32'd2);
    check("r1234_req_hi",   32'(req_hi_cycles),   32'd1);
    check("r1234_rdata",    32'(bus.cpu_read_data), 32'hA5);
    check("r1234_addr",     32'(bus.mem_addr),    32'h1234);
    idle(2);

    // Write 8'h3C to 16'h01FF, ack on the fifth WAIT cycle
    do_access(1'b0, 1'b1, 16'h01FF, 8'h3C, 5, 8'h99);
    check("w01ff_req_hi", 32'(req_hi_cycles),       32'd5);
    check("w01ff_rdata",  32'(bus.cpu_read_data),   32'hA5);
    idle(1);

    // Read with no acknowledge: timeout
    do_access(1'b1, 1'b0, 16'h0042, 8'h00, 0, 8'h00);
    check("tmo_req_hi", 32'(req_hi_cycles),     32'd16);
    check("tmo_err_hi", 32'(err_hi_cycles),     32'd1);
    check("tmo_rdata",  32'(bus.cpu_read_data), 32'hFF);
    idle(1);

    // Read and write together: performed as write
    do_access(1'b1, 1'b1, 16'hC0DE, 8'h81, 2, 8'h11);
    check("rw_rdata", 32'(bus.cpu_read_data), 32'hFF);
    idle(1);

    // Ack in the very timeout cycle wins
    do_access(1'b1, 1'b0, 16'h7777, 8'h00, 16, 8'h5A);
    check("edge_err_hi", 32'(err_hi_cycles),     32'd0);
    check("edge_req_hi", 32'(req_hi_cycles),     32'd16);
    check("edge_rdata",  32'(bus.cpu_read_data), 32'h5A);

    // Randomized traffic, including back-to-back accesses and timeouts
    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      do_access(sel != 1, sel != 0, 16'($urandom), 8'($urandom),
                int'($urandom_range(0, T + 4)), 8'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of WAIT
    tick();
    bus.cpu_read_req   = 1'b1;
    bus.cpu_write_req  = 1'b0;
    bus.cpu_addr_high  = 8'hBE;
    bus.cpu_addr_low   = 8'hEF;
    bus.cpu_write_data = 8'h00;
    bus.mem_ack        = 1'b0;
    exp_req     = 1'b0;
    exp_err     = 1'b0;
    exp_ready   = 1'b0;
    exp_bus_chk = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      tick();
      bus.cpu_read_req = 1'b0;
      bus.mem_ack      = 1'b0;
      exp_req     = 1'b1;
      exp_addr    = 16'hBEEF;
      exp_wdata   = 8'h00;
      exp_we      = 1'b0;
      exp_ready   = 1'b0;
      exp_bus_chk = 1'b1;
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midwait_rst_req",   32'(bus.mem_req),   32'h0);
    check("midwait_rst_ready", 32'(bus.cpu_ready), 32'h1);
    set_reset_expect();
    @(negedge clk);
    #1;
    rst         = 1'b0;
    exp_bus_chk = 1'b0;
    idle(1);
    do_access(1'b1, 1'b0, 16'h2468, 8'h00, 3, 8'h77);
    check("post_rst_rdata", 32'(bus.cpu_read_data), 32'h77);
    check("post_rst_err",   32'(err_hi_cycles),     32'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
